fib_bcd_conv: RTL and testbench
===============================

Name: fib_bcd_conv

Overview:
- Downstream stage of the Fibonacci generator.
- Consumes the 20-bit result f_o, captured on the generator's done_tick_o, and converts it to packed BCD for display/scoreboard logic.
- Iterative shift-add-3 (double dabble): one bit per cycle, ready/start/done_tick handshake in the same style as the generator, so the generator's done_tick_o can drive start_i directly.

Parameters:
- BIN_WIDTH, 20, width of binary input; matches generator f_o width.
- DIGITS, 7, number of BCD digits in the output. 7 covers 2^20-1 = 1048575. Must satisfy 10^DIGITS > 2^BIN_WIDTH-1.

Ports:
- clk_i  in  1  single clock, all state on rising edge.
- rst_i  in  1  synchronous, active-low reset.
- start_i  in  1  conversion request; sampled only when ready_o=1.
- bin_i  in  BIN_WIDTH  binary value; captured on the accepted start edge only.
- ready_o  out  1  high when idle and able to accept start_i.
- done_tick_o  out  1  one-cycle pulse; bcd_o holds the new result in this cycle.
- bcd_o  out  4*DIGITS  packed BCD; digit k in bits [4k+3:4k], digit 0 = least significant.

Behaviour:
- Interface: one clock clk_i; reset rst_i is synchronous and active-low (rst_i=0 sampled at a clock edge resets all state).
- Reset values: state=IDLE, ready_o=1, done_tick_o=0, bcd_o=0, internal shift/BCD/count registers=0.
- FSM states: IDLE, OP, DONE.
- IDLE:
  - ready_o=1.
  - On start_i=1: load bin_i into the shift register, clear the BCD accumulator, count=BIN_WIDTH-1, go to OP.
- OP:
  - ready_o=0.
  - Each cycle: every accumulator digit >=5 gets +3 (all digits in parallel, combinational).
  - Then {acc, shreg} shifts left 1, bringing shreg MSB into acc bit 0.
  - count decrements; on the cycle count==0, the final shift result is written to bcd_o and the FSM goes to DONE.
  - Exactly BIN_WIDTH OP cycles.
- DONE:
  - done_tick_o=1, ready_o=0 for exactly one cycle, then go to IDLE.
  - start_i in DONE is ignored.
- Latency: start accepted at edge E0 → done_tick_o high in the cycle after edge E0+BIN_WIDTH (i.e. BIN_WIDTH+1 cycles after the start edge). Minimum start-to-start spacing is BIN_WIDTH+2 cycles.
- bcd_o:
  - Changes only on the edge entering DONE (or on reset).
  - Holds the last result indefinitely, including through later conversions until their own DONE.
- start_i while ready_o=0: ignored, no queuing; bin_i changes during OP have no effect.
- Simultaneous reset and start: reset wins; no conversion begins.
- Reset mid-OP: conversion aborted, bcd_o cleared to 0, no done_tick_o pulse.
- Arithmetic:
  - The add-3 carry never leaves its 4-bit digit (digit <=9 after shift by construction).
  - Accumulator is 4*DIGITS bits; bits shifted out of the top are discarded. This cannot occur under the DIGITS constraint.
- bin_i = 0 is legal: full BIN_WIDTH cycles run, result all-zero.

Optional Feature:
- Macro FIB_BCD_BLANK_EN.
- Defined:
  - Adds output port blank_o, width DIGITS, reset 0.
  - Updated on the same edge as bcd_o.
  - blank_o[k]=1 iff digit k and all higher digits are zero, for k>=1. blank_o[0] is always 0, so value 0 displays a single "0".
  - Held with bcd_o.
- Not defined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset released, start_i=1 with bin_i=0 → ready_o drops next cycle; done_tick_o high exactly 21 cycles after the start edge; bcd_o=0x0000000.
- bin_i=832040 (fib(30)) → bcd_o=0x0832040 with done_tick_o single-cycle pulse; ready_o high again the following cycle.
- bin_i=1048575 (all ones) → bcd_o=0x1048575; bin_i=9 → 0x0000009; bin_i=10 → 0x0000010 (add-3 boundary).
- Start with bin_i=6765; pulse start_i with bin_i=55 at cycle 5 and toggle bin_i during OP → bcd_o=0x0006765; no second done_tick_o; 55 never appears.
- Start 832040; drive rst_i=0 for one cycle at cycle 10 → no done_tick_o; bcd_o=0, ready_o=1. Then start 144 → bcd_o=0x0000144.
- FIB_BCD_BLANK_EN defined, bin_i=144 → blank_o=7'b1111000. bin_i=0 → blank_o=7'b1111110. Not defined: elaboration succeeds without blank_o.

Source files
------------

// File: rtl/fib_bcd_conv.sv
// fib_bcd_conv: iterative double-dabble binary-to-BCD converter; optional blank_o via FIB_BCD_BLANK_EN
module fib_bcd_conv #(
    parameter int BIN_WIDTH = 20,
    parameter int DIGITS    = 7
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [BIN_WIDTH-1:0]   bin_i,
    output logic                   ready_o,
    output logic                   done_tick_o,
    output logic [4*DIGITS-1:0]    bcd_o
`ifdef FIB_BCD_BLANK_EN
    ,
    output logic [DIGITS-1:0]      blank_o
`endif
);
    localparam int CW = $clog2(BIN_WIDTH);
    typedef enum logic [1:0] {IDLE, OP, DONE} state_t;
    state_t state, state_nxt;
    logic [BIN_WIDTH-1:0] shreg;
    logic [4*DIGITS-1:0] acc, acc_nxt;
    logic [CW-1:0] cnt;
    logic [3:0] d;
    logic cin;
    // state register
    always_ff @(posedge clk_i)
        state <= !rst_i ? IDLE : state_nxt;
    // next-state logic
    always_comb
        state_nxt = (state == IDLE) ? (start_i ? OP : IDLE) :
                    (state == OP)   ? (cnt == '0 ? DONE : OP) : IDLE;
    // outputs decoded from state
    always_comb begin
        ready_o     = state == IDLE;
        done_tick_o = state == DONE;
    end
    // add-3 on every digit >=5, then shift {acc, shreg} left by one
    always_comb begin
        acc_nxt = '0;
        d       = '0;
        cin     = shreg[BIN_WIDTH-1];
        for (int k = 0; k < DIGITS; k++) begin
            d = acc[4*k +: 4];
            d = (d >= 4'd5) ? d + 4'd3 : d;
            acc_nxt[4*k +: 4] = {d[2:0], cin};
            cin = d[3];
        end
    end
    // datapath: load on accepted start, iterate in OP, publish result on last shift
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            shreg <= '0;
            acc   <= '0;
            cnt   <= '0;
            bcd_o <= '0;
        end else if (state == IDLE && start_i) begin
            shreg <= bin_i;
            acc   <= '0;
            cnt   <= CW'(BIN_WIDTH-1);
        end else if (state == OP) begin
            shreg <= {shreg[BIN_WIDTH-2:0], 1'b0};
            acc   <= acc_nxt;
            cnt   <= cnt - CW'(1);
            if (cnt == '0)
                bcd_o <= acc_nxt;
        end
    end
`ifdef FIB_BCD_BLANK_EN
    logic [DIGITS-1:0] blank_nxt;
    logic zero_above;
    // leading-zero blanking: digit k blank when it and all higher digits are zero; digit 0 never blank
    always_comb begin
        blank_nxt  = '0;
        zero_above = 1'b1;
        for (int k = DIGITS-1; k >= 1; k--) begin
            zero_above   = zero_above & (acc_nxt[4*k +: 4] == 4'd0);
            blank_nxt[k] = zero_above;
        end
    end
    // blanking mask updates together with bcd_o
    always_ff @(posedge clk_i) begin
        if (!rst_i)
            blank_o <= '0;
        else if (state == OP && cnt == '0)
            blank_o <= blank_nxt;
    end
`endif
endmodule

// File: tb/tb_fib_bcd_conv.sv
// tb_fib_bcd_conv: directed self-checking bench for fib_bcd_conv
module tb_fib_bcd_conv;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_i = 1'b0;
    logic [19:0] bin_i = '0;
    logic        ready_o, done_tick_o;
    logic [27:0] bcd_o;
    int checks = 0;
    int failures = 0;
    int cyc;
    int pulses;
`ifdef FIB_BCD_BLANK_EN
    logic [6:0] blank_o;
`endif

    fib_bcd_conv dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .start_i(start_i),
        .bin_i(bin_i),
        .ready_o(ready_o),
        .done_tick_o(done_tick_o),
        .bcd_o(bcd_o)
`ifdef FIB_BCD_BLANK_EN
        ,
        .blank_o(blank_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // issue start on one edge; return at the negedge right after the start edge
    task automatic issue(input logic [19:0] v);
        @(negedge clk_i);
        start_i = 1'b1;
        bin_i   = v;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    // wait (bounded) for done_tick_o; cyc = edges after the start edge
    task automatic wait_done();
        cyc = 0;
        while (!done_tick_o && cyc < 40) begin
            @(negedge clk_i);
            cyc++;
        end
    endtask

    task automatic watch_none(input int n);
        pulses = 0;
        repeat (n) begin
            @(negedge clk_i);
            if (done_tick_o) pulses++;
        end
    endtask

    task automatic run(input string tag, input logic [19:0] v, input logic [27:0] exp, input logic [6:0] bexp);
        issue(v);
        chk({tag, "_ready_low"}, ready_o, 0);
        wait_done();
        chk({tag, "_latency"}, cyc, 20);
        chk({tag, "_bcd"}, bcd_o, exp);
`ifdef FIB_BCD_BLANK_EN
        chk({tag, "_blank"}, blank_o, bexp);
`endif
        @(negedge clk_i);
        chk({tag, "_done_single"}, done_tick_o, 0);
        chk({tag, "_ready_back"}, ready_o, 1);
        chk({tag, "_bcd_hold"}, bcd_o, exp);
    endtask

    initial begin
        repeat (3) @(negedge clk_i);
        chk("rst_ready", ready_o, 1);
        chk("rst_done", done_tick_o, 0);
        chk("rst_bcd", bcd_o, 0);
        // reset and start together: reset wins
        start_i = 1'b1;
        bin_i   = 20'd77;
        @(negedge clk_i);
        start_i = 1'b0;
        rst_i   = 1'b1;
        @(negedge clk_i);
        chk("rst_start_ready", ready_o, 1);
        watch_none(25);
        chk("rst_start_no_done", pulses, 0);

        run("zero", 20'd0, 28'h0000000, 7'b1111110);
        run("fib30", 20'd832040, 28'h0832040, 7'b1000000);
        run("ones", 20'd1048575, 28'h1048575, 7'b0000000);
        run("nine", 20'd9, 28'h0000009, 7'b1111110);
        run("ten", 20'd10, 28'h0000010, 7'b1111100);

        // start ignored while busy; bin_i changes during OP have no effect
        issue(20'd6765);
        repeat (4) @(negedge clk_i);
        chk("busy_hold_old_bcd", bcd_o, 28'h0000010);
        start_i = 1'b1;
        bin_i   = 20'd55;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (6) begin
            bin_i = 20'($urandom);
            @(negedge clk_i);
        end
        cyc = 11;
        while (!done_tick_o && cyc < 40) begin
            @(negedge clk_i);
            cyc++;
        end
        chk("busy_latency", cyc, 20);
        chk("busy_bcd", bcd_o, 28'h0006765);
        watch_none(30);
        chk("busy_no_second_done", pulses, 0);
        chk("busy_bcd_final", bcd_o, 28'h0006765);

        // reset mid-conversion aborts and clears
        issue(20'd832040);
        repeat (9) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        chk("abort_bcd", bcd_o, 0);
        chk("abort_ready", ready_o, 1);
        watch_none(25);
        chk("abort_no_done", pulses, 0);
        run("after_abort", 20'd144, 28'h0000144, 7'b1111000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
